// File: rtl/pll_sup_pkg.sv
// Shared state encoding and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  localparam logic [2:0] ST_PWD  = 3'd0;
  localparam logic [2:0] ST_RST  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_FAIL = 3'd4;

  localparam int SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    S_PWD  = ST_PWD,
    S_RST  = ST_RST,
    S_WAIT = ST_WAIT,
    S_RUN  = ST_RUN,
    S_FAIL = ST_FAIL
  } state_e;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_sup_sync2.sv
// Flop-chain synchronizer bringing the asynchronous PLL lock into the reference clock domain.
module pll_sup_sync2
  import pll_sup_pkg::*;
(
  input  logic clk_i,
  input  logic srst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_DEPTH-1:0] ff_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[SYNC_DEPTH-2:0], d_i};
    end
  end

  assign q_o = ff_q[SYNC_DEPTH-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL power-down/reset sequencer, lock qualifier and watchdog with bounded retries.
// Defining PLL_SUP_LOSS_CNT_EN adds the saturating lock-loss counter output loss_cnt.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PWD_CYCLES    = 2,
  parameter int RST_CYCLES    = 2,
  parameter int STABLE_CYCLES = 256,
  parameter int LOCK_TIMEOUT  = 2700,
  parameter int MAX_RETRY     = 3
) (
  input  logic clkin1,
  input  logic rst,
  input  logic lock,
  input  logic restart,
  output logic pll_pwd,
  output logic pll_rst,
  output logic sys_rst,
  output logic locked_ok,
  output logic lock_lost,
  output logic fail
`ifdef PLL_SUP_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  localparam int MAX_PARAM = max_of(max_of(max_of(PWD_CYCLES, RST_CYCLES),
                                           max_of(STABLE_CYCLES, LOCK_TIMEOUT)), MAX_RETRY);
  localparam int CNT_W   = $clog2(MAX_PARAM + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   PWD_LAST    = CNT_W'(PWD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STAB_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     stab_q, stab_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 pwd_q, pwd_d;
  logic                 prst_q, prst_d;
  logic                 sysrst_q, sysrst_d;
  logic                 ok_q, ok_d;
  logic                 lost_q, lost_d;
  logic                 fail_q, fail_d;
  logic                 lock_s;

  pll_sup_sync2 u_lock_sync (
    .clk_i  (clkin1),
    .srst_i (rst),
    .d_i    (lock),
    .q_o    (lock_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    stab_d  = '0;
    cnt_d   = cnt_q + 1'b1;

    case (state_q)
      S_PWD:  if (cnt_q == PWD_LAST) state_d = S_RST;
      S_RST:  if (cnt_q == RST_LAST) state_d = S_WAIT;
      S_WAIT: begin
        stab_d = lock_s ? stab_q + 1'b1 : '0;
        // A lock that qualifies on the timeout cycle still counts as a success.
        if (lock_s && (stab_q == STAB_LAST)) begin
          state_d = S_RUN;
          retry_d = '0;
        end else if (cnt_q == TMO_LAST) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_d == RETRY_LIMIT) ? S_FAIL : S_PWD;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_PWD;
          lost_d  = 1'b1;
        end
      end
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_PWD;
    endcase

    if (restart) begin
      state_d = S_PWD;
      retry_d = '0;
      lost_d  = 1'b0;
    end

    // A restart from PWD must still restart the power-down timing from zero.
    if (restart || (state_d != state_q) || (state_q == S_RUN) || (state_q == S_FAIL)) begin
      cnt_d = '0;
    end
    if (restart || (state_d != state_q)) begin
      stab_d = '0;
    end

    pwd_d    = (state_d == S_PWD) || (state_d == S_FAIL);
    prst_d   = (state_d == S_PWD) || (state_d == S_RST) || (state_d == S_FAIL);
    sysrst_d = (state_d != S_RUN);
    ok_d     = (state_d == S_RUN);
    fail_d   = (state_d == S_FAIL);
  end

  always_ff @(posedge clkin1) begin
    if (rst) begin
      state_q  <= S_PWD;
      cnt_q    <= '0;
      stab_q   <= '0;
      retry_q  <= '0;
      pwd_q    <= 1'b1;
      prst_q   <= 1'b1;
      sysrst_q <= 1'b1;
      ok_q     <= 1'b0;
      lost_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stab_q   <= stab_d;
      retry_q  <= retry_d;
      pwd_q    <= pwd_d;
      prst_q   <= prst_d;
      sysrst_q <= sysrst_d;
      ok_q     <= ok_d;
      lost_q   <= lost_d;
      fail_q   <= fail_d;
    end
  end

  assign pll_pwd   = pwd_q;
  assign pll_rst   = prst_q;
  assign sys_rst   = sysrst_q;
  assign locked_ok = ok_q;
  assign lock_lost = lost_q;
  assign fail      = fail_q;

`ifdef PLL_SUP_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;

  // Only a genuine RUN->PWD drop counts; a restart in the same cycle takes precedence.
  always_comb begin
    loss_d = loss_q;
    if ((state_q == S_RUN) && !lock_s && !restart && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge clkin1) begin
    if (rst) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench: timeline-based reference model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

  localparam int P  = 2;
  localparam int R  = 2;
  localparam int S  = 8;
  localparam int T  = 40;
  localparam int MR = 2;

  logic clkin1  = 1'b0;
  logic rst     = 1'b1;
  logic lock    = 1'b0;
  logic restart = 1'b0;
  logic pll_pwd, pll_rst, sys_rst, locked_ok, lock_lost, fail;
`ifdef PLL_SUP_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  pll_lock_supervisor #(
    .PWD_CYCLES    (P),
    .RST_CYCLES    (R),
    .STABLE_CYCLES (S),
    .LOCK_TIMEOUT  (T),
    .MAX_RETRY     (MR)
  ) dut (
    .clkin1    (clkin1),
    .rst       (rst),
    .lock      (lock),
    .restart   (restart),
    .pll_pwd   (pll_pwd),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .locked_ok (locked_ok),
    .lock_lost (lock_lost),
    .fail      (fail)
`ifdef PLL_SUP_LOSS_CNT_EN
    ,
    .loss_cnt  (loss_cnt)
`endif
  );

  always #5 clkin1 = ~clkin1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: an attempt is a timeline measured by its age in cycles.
  typedef enum int {M_SEQ, M_RUN, M_DEAD} mode_t;
  mode_t m_mode = M_SEQ;
  int    m_age = 0, m_run = 0, m_retries = 0, m_losses = 0;
  bit    m_lost = 1'b0;
  bit    pin_d1 = 1'b0, pin_d2 = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  task automatic model_step();
    bit ls;
    ls = pin_d2;
    if (rst) begin
      m_mode = M_SEQ; m_age = 0; m_run = 0; m_retries = 0;
      m_lost = 1'b0; m_losses = 0; pin_d1 = 1'b0; pin_d2 = 1'b0;
      return;
    end
    pin_d2 = pin_d1;
    pin_d1 = lock;
    if (restart) begin
      m_mode = M_SEQ; m_age = 0; m_run = 0; m_retries = 0; m_lost = 1'b0;
      return;
    end
    case (m_mode)
      M_SEQ: begin
        if (m_age < P + R) begin
          m_age++;
        end else begin
          m_run = ls ? m_run + 1 : 0;
          if (m_run >= S) begin
            m_mode = M_RUN; m_retries = 0;
          end else if (m_age - (P + R) == T - 1) begin
            m_retries++; m_age = 0; m_run = 0;
            if (m_retries == MR) m_mode = M_DEAD;
          end else begin
            m_age++;
          end
        end
      end
      M_RUN: begin
        if (!ls) begin
          m_mode = M_SEQ; m_age = 0; m_run = 0; m_lost = 1'b1;
          if (m_losses < 255) m_losses++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clkin1);
    model_step();
    @(negedge clkin1);
  endtask

  // Compare process: every cycle once the first reset has been applied.
  always @(negedge clkin1) begin
    if (chk_en) begin
      check("pll_pwd",   int'(pll_pwd),   int'((m_mode == M_DEAD) || (m_mode == M_SEQ && m_age < P)));
      check("pll_rst",   int'(pll_rst),   int'((m_mode == M_DEAD) || (m_mode == M_SEQ && m_age < P + R)));
      check("sys_rst",   int'(sys_rst),   int'(m_mode != M_RUN));
      check("locked_ok", int'(locked_ok), int'(m_mode == M_RUN));
      check("fail",      int'(fail),      int'(m_mode == M_DEAD));
      check("lock_lost", int'(lock_lost), int'(m_lost));
`ifdef PLL_SUP_LOSS_CNT_EN
      check("loss_cnt",  int'(loss_cnt),  m_losses);
`endif
    end
  end

  task automatic wait_locked(input string name, input int budget);
    int n;
    n = 0;
    while (!locked_ok && n < budget) begin
      tick();
      n++;
    end
    check(name, int'(locked_ok), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pwd"},  int'(pll_pwd),   1);
    check({tag, "_prst"}, int'(pll_rst),   1);
    check({tag, "_sys"},  int'(sys_rst),   1);
    check({tag, "_ok"},   int'(locked_ok), 0);
    check({tag, "_lost"}, int'(lock_lost), 0);
    check({tag, "_fail"}, int'(fail),      0);
  endtask

`ifdef PLL_SUP_LOSS_CNT_EN
  task automatic lose_and_relock();
    lock = 1'b0; tick();
    lock = 1'b1; tick(); tick();
    wait_locked("loss_relock", 60);
  endtask
`endif

  initial begin
    int bad;
    int len, mode;

    // Scenario 1: power-up; edge 0 is the last reset edge.
    rst = 1'b1; lock = 1'b0;
    tick(); chk_en = 1'b1; tick(); tick();
    check_reset_values("s1_reset");
    rst = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      if (e == 10) lock = 1'b1;
      tick();
      if (e == 1)  check("s1_pwd_e1",  int'(pll_pwd), 1);
      if (e == 2)  check("s1_pwd_e2",  int'(pll_pwd), 0);
      if (e == 3)  check("s1_prst_e3", int'(pll_rst), 1);
      if (e == 4)  check("s1_prst_e4", int'(pll_rst), 0);
      if (e == 18) check("s1_sys_e18", int'(sys_rst), 1);
      if (e == 19) begin
        check("s1_sys_e19", int'(sys_rst), 0);
        check("s1_ok_e19",  int'(locked_ok), 1);
        check("s1_lost_e19", int'(lock_lost), 0);
      end
    end
    $display("scenario 1: power-up lock reached at edge 19");

    // Scenario 4: lock drop in RUN, then relock.
    lock = 1'b0;
    tick(); check("s4_sys_t1", int'(sys_rst), 0);
    tick(); check("s4_sys_t2", int'(sys_rst), 0);
    tick();
    check("s4_sys_t3",  int'(sys_rst), 1);
    check("s4_lost_t3", int'(lock_lost), 1);
    check("s4_pwd_t3",  int'(pll_pwd), 1);
    tick(); check("s4_pwd_t4", int'(pll_pwd), 1);
    tick(); check("s4_pwd_t5", int'(pll_pwd), 0);
    repeat (15) tick();
    lock = 1'b1;
    wait_locked("s4_relock", 60);
    check("s4_lost_sticky", int'(lock_lost), 1);
    $display("scenario 4: lock loss detected and relocked");

    // Scenario 5b: rst mid-WAIT returns every output to its reset value.
    lock = 1'b0;
    repeat (10) tick();
    check("s5_in_wait", int'(pll_rst), 0);
    check("s5_lost_before", int'(lock_lost), 1);
    rst = 1'b1; tick();
    check_reset_values("s5_rst");
    $display("scenario 5b: rst mid-wait");

    // Scenario 2: 5-high/1-low lock pattern never qualifies.
    tick(); rst = 1'b0; bad = 0;
    for (int e = 1; e <= 88; e++) begin
      lock = ((e % 6) != 0);
      tick();
      if (!sys_rst) bad++;
      if (e == 43) check("s2_wait_e43", int'(pll_rst), 0);
      if (e == 44) check("s2_retry_pwd", int'(pll_pwd), 1);
      if (e == 87) check("s2_fail_e87", int'(fail), 0);
      if (e == 88) check("s2_fail_e88", int'(fail), 1);
    end
    check("s2_sys_never_low", bad, 0);
    $display("scenario 2: glitchy lock timed out twice");

    // Scenario 3: lock held low exhausts the retries and holds.
    rst = 1'b1; tick(); rst = 1'b0; lock = 1'b0;
    for (int e = 1; e <= 88; e++) begin
      tick();
      if (e == 44) check("s3_retry_pwd", int'(pll_pwd), 1);
      if (e == 87) check("s3_fail_e87", int'(fail), 0);
      if (e == 88) check("s3_fail_e88", int'(fail), 1);
    end
    bad = 0;
    repeat (200) begin
      tick();
      if (!pll_pwd || !sys_rst || !fail) bad++;
    end
    check("s3_hold", bad, 0);
    $display("scenario 3: retries exhausted, held for 200 cycles");

    // Scenario 5a: restart leaves the dead state and a full sequence runs.
    restart = 1'b1; lock = 1'b1; tick(); restart = 1'b0;
    check("s5_restart_fail", int'(fail), 0);
    check("s5_restart_pwd",  int'(pll_pwd), 1);
    wait_locked("s5_restart_lock", 60);
    $display("scenario 5a: restart from dead state relocked");

    // Scenario 5c: rst and restart together.
    rst = 1'b1; restart = 1'b1; tick(); rst = 1'b0; restart = 1'b0;
    check_reset_values("s5_both");
    $display("scenario 5c: rst with restart");

    // Randomized segments checked by the compare process.
    for (int seg = 0; seg < 60; seg++) begin
      len  = $urandom_range(20, 120);
      mode = $urandom_range(0, 3);
      for (int i = 0; i < len; i++) begin
        case (mode)
          0:       lock = 1'b1;
          1:       lock = 1'b0;
          2:       lock = ($urandom_range(0, 9) != 0);
          default: lock = $urandom_range(0, 1);
        endcase
        restart = ($urandom_range(0, 149) == 0);
        rst     = ($urandom_range(0, 399) == 0);
        tick();
      end
    end
    rst = 1'b0; restart = 1'b0;
    $display("random: 60 segments done");

`ifdef PLL_SUP_LOSS_CNT_EN
    // Scenario 6: loss counter behaviour.
    rst = 1'b1; tick(); rst = 1'b0; lock = 1'b1;
    wait_locked("s6_first_lock", 60);
    repeat (3) lose_and_relock();
    check("s6_loss3", int'(loss_cnt), 3);
    restart = 1'b1; tick(); restart = 1'b0;
    check("s6_restart_keeps", int'(loss_cnt), 3);
    rst = 1'b1; tick(); rst = 1'b0;
    check("s6_rst_clears", int'(loss_cnt), 0);
    wait_locked("s6_lock_again", 60);
    repeat (300) lose_and_relock();
    check("s6_saturate", int'(loss_cnt), 255);
    $display("scenario 6: loss counter saturates");
`endif

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
